// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory port: funct3 encodings,
// FSM state encoding, response error codes, the latched request record and
// the request legality check used at the handshake.
package lsu_pkg;

    localparam int XLEN = 32;

    // RV32 funct3 encodings (stores reuse B/H/W).
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic            write;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    // Unsupported encodings are reported the same way as misalignment, so a
    // single flag decides whether the bus is touched at all.
    function automatic logic req_illegal(input logic       write,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = addr_lo[0];
            F3_W:        bad = (addr_lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        // Unsigned variants exist only for loads.
        if (write && funct3[2]) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_port_align.sv
// Byte-lane steering for the load/store port (purely combinational).
//   funct3     : access size / signedness of the latched request
//   addr_lo    : byte offset within the word
//   wdata      : LSB-aligned store data
//   rdata      : raw word from the bus
//   be         : byte enables for the bus access
//   wdata_lane : store data replicated into the addressed lanes
//   rdata_ext  : addressed byte/half/word, sign- or zero-extended
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]              funct3,
    input  logic [1:0]              addr_lo,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH-1:0]   rdata,
    output logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   wdata_lane,
    output logic [DATA_WIDTH-1:0]   rdata_ext
);

    localparam int NUM_LANES = DATA_WIDTH / 8;

    logic [NUM_LANES-1:0][7:0] lane_wd;
    logic [1:0]                size;

    assign size = funct3[1:0];

    // Each lane decides its own enable and data source. Byte stores put the
    // low byte in every lane and halves fill both halves, so the memory only
    // needs the enables to pick the right bytes.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [1:0] LANE = 2'(i);
        assign be[i] = (size == 2'b00) ? (addr_lo == LANE)       :
                       (size == 2'b01) ? (addr_lo[1] == LANE[1]) : 1'b1;
        assign lane_wd[i] = (size == 2'b00) ? wdata[7:0]            :
                            (size == 2'b01) ? wdata[8*(i%2) +: 8]   :
                                              wdata[8*i +: 8];
    end

    assign wdata_lane = lane_wd;

    logic [4:0]  b_lsb;
    logic [4:0]  h_lsb;
    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    assign b_lsb = {addr_lo, 3'b000};
    assign h_lsb = {addr_lo[1], 4'b0000};
    assign b_sel = rdata[b_lsb +: 8];
    assign h_sel = rdata[h_lsb +: 16];

    always_comb begin
        rdata_ext = rdata;
        case (funct3)
            F3_B:  rdata_ext = {{(DATA_WIDTH-8){b_sel[7]}}, b_sel};
            F3_H:  rdata_ext = {{(DATA_WIDTH-16){h_sel[15]}}, h_sel};
            F3_BU: rdata_ext = {{(DATA_WIDTH-8){1'b0}}, b_sel};
            F3_HU: rdata_ext = {{(DATA_WIDTH-16){1'b0}}, h_sel};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port between the execute/memory stage and the data bus.
// One request at a time: latched on LSU_Req_Valid && LSU_Req_Ready, issued
// as a word-aligned bus access, answered with a one-cycle LSU_Rsp_Valid.
//   REG_Clk, REG_Reset       : clock, async active-high reset
//   LSU_Req_*                : core request (valid/ready, write, funct3,
//                              byte address, LSB-aligned store data)
//   LSU_Rsp_*                : completion pulse, extended load data, error
//   MEM_Valid/Ready/Write/Addr/WData/BE : bus request channel
//   MEM_RValid/RData         : bus read-data channel
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                    REG_Clk,
    input  logic                    REG_Reset,
    input  logic                    LSU_Req_Valid,
    output logic                    LSU_Req_Ready,
    input  logic                    LSU_Req_Write,
    input  logic [2:0]              LSU_Req_Funct3,
    input  logic [31:0]             LSU_Req_Addr,
    input  logic [DATA_WIDTH-1:0]   LSU_Req_WData,
    output logic                    LSU_Rsp_Valid,
    output logic [DATA_WIDTH-1:0]   LSU_Rsp_RData,
    output logic [1:0]              LSU_Rsp_Error,
    output logic                    MEM_Valid,
    input  logic                    MEM_Ready,
    output logic                    MEM_Write,
    output logic [31:0]             MEM_Addr,
    output logic [DATA_WIDTH-1:0]   MEM_WData,
    output logic [DATA_WIDTH/8-1:0] MEM_BE,
    input  logic                    MEM_RValid,
    input  logic [DATA_WIDTH-1:0]   MEM_RData
);

    lsu_state_e              state_q, state_d;
    lsu_req_t                req_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic [1:0]              err_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    illegal;
    logic                    expire;
    logic                    ld_capture;
    logic                    timeout_hit;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata_lane;
    logic [DATA_WIDTH-1:0]   rdata_ext;

    lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3     (req_q.funct3),
        .addr_lo    (req_q.addr[1:0]),
        .wdata      (req_q.wdata),
        .rdata      (MEM_RData),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    assign illegal = req_illegal(LSU_Req_Write, LSU_Req_Funct3, LSU_Req_Addr[1:0]);

    // The counter is 0 in the first ISSUE cycle, so this is the last cycle
    // of the budget. A bus event in the same cycle still completes normally.
    assign expire = (cnt_q >= CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    assign ld_capture = !req_q.write && MEM_RValid &&
                        ((state_q == ISSUE && MEM_Ready) || state_q == WAIT_R);

    assign timeout_hit = expire &&
                         ((state_q == ISSUE  && !MEM_Ready) ||
                          (state_q == WAIT_R && !MEM_RValid));

    // State register
    always_ff @(posedge REG_Clk or posedge REG_Reset) begin
        if (REG_Reset) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (LSU_Req_Valid) state_d = illegal ? RESP : ISSUE;
            ISSUE: begin
                if (MEM_Ready)   state_d = (req_q.write || MEM_RValid) ? RESP : WAIT_R;
                else if (expire) state_d = RESP;
            end
            WAIT_R: if (MEM_RValid || expire) state_d = RESP;
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are Moore: everything is zero outside the state that owns it,
    // which also gives the all-zero reset view.
    always_comb begin
        LSU_Req_Ready = 1'b0;
        LSU_Rsp_Valid = 1'b0;
        LSU_Rsp_RData = '0;
        LSU_Rsp_Error = ERR_OK;
        MEM_Valid     = 1'b0;
        MEM_Write     = 1'b0;
        MEM_Addr      = '0;
        MEM_WData     = '0;
        MEM_BE        = '0;
        case (state_q)
            IDLE: LSU_Req_Ready = 1'b1;
            ISSUE: begin
                MEM_Valid = 1'b1;
                MEM_Write = req_q.write;
                MEM_Addr  = {req_q.addr[31:2], 2'b00};
                MEM_WData = wdata_lane;
                MEM_BE    = be;
            end
            RESP: begin
                LSU_Rsp_Valid = 1'b1;
                LSU_Rsp_RData = rdata_q;
                LSU_Rsp_Error = err_q;
            end
            default: ;
        endcase
    end

    // Request latch, timeout counter and response data
    always_ff @(posedge REG_Clk or posedge REG_Reset) begin
        if (REG_Reset) begin
            req_q   <= '0;
            cnt_q   <= '0;
            err_q   <= ERR_OK;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (LSU_Req_Valid) begin
                    req_q   <= '{write:  LSU_Req_Write,
                                 funct3: LSU_Req_Funct3,
                                 addr:   LSU_Req_Addr,
                                 wdata:  LSU_Req_WData};
                    err_q   <= illegal ? ERR_MISALIGN : ERR_OK;
                    rdata_q <= '0;
                    cnt_q   <= '0;
                end
                ISSUE, WAIT_R: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (ld_capture)  rdata_q <= rdata_ext;
                    if (timeout_hit) err_q   <= ERR_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;
    logic        REG_Clk = 1'b0;
    logic        REG_Reset;
    logic        LSU_Req_Valid, LSU_Req_Ready, LSU_Req_Write;
    logic [2:0]  LSU_Req_Funct3;
    logic [31:0] LSU_Req_Addr, LSU_Req_WData;
    logic        LSU_Rsp_Valid;
    logic [31:0] LSU_Rsp_RData;
    logic [1:0]  LSU_Rsp_Error;
    logic        MEM_Valid, MEM_Ready, MEM_Write;
    logic [31:0] MEM_Addr, MEM_WData;
    logic [3:0]  MEM_BE;
    logic        MEM_RValid;
    logic [31:0] MEM_RData;

    lsu_mem_port dut (
        .REG_Clk(REG_Clk), .REG_Reset(REG_Reset),
        .LSU_Req_Valid(LSU_Req_Valid), .LSU_Req_Ready(LSU_Req_Ready),
        .LSU_Req_Write(LSU_Req_Write), .LSU_Req_Funct3(LSU_Req_Funct3),
        .LSU_Req_Addr(LSU_Req_Addr), .LSU_Req_WData(LSU_Req_WData),
        .LSU_Rsp_Valid(LSU_Rsp_Valid), .LSU_Rsp_RData(LSU_Rsp_RData),
        .LSU_Rsp_Error(LSU_Rsp_Error),
        .MEM_Valid(MEM_Valid), .MEM_Ready(MEM_Ready), .MEM_Write(MEM_Write),
        .MEM_Addr(MEM_Addr), .MEM_WData(MEM_WData), .MEM_BE(MEM_BE),
        .MEM_RValid(MEM_RValid), .MEM_RData(MEM_RData)
    );

    always #5 REG_Clk = ~REG_Clk;

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        int          rdy_dly;   // ISSUE cycles with MEM_Ready low before acceptance
        int          rv_dly;    // cycles from acceptance to MEM_RValid (0 = same cycle)
    } txn_t;

    typedef struct {
        bit          done;
        int          lat, iss;
        logic [1:0]  err;
        logic [31:0] rdata, maddr, mwd;
        logic [3:0]  be;
        logic        mwr;
        bit          unstable, busy_ready, pulse_bad;
    } res_t;

    typedef struct {
        txn_t        t;
        logic [1:0]  err;
        logic [31:0] rdata;
        int          lat, iss;
        logic [31:0] maddr, mwd;
        logic [3:0]  be;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: derived from access size, offset and a 16-cycle budget in
    // which a bus event arriving in the last cycle still counts.
    function automatic res_t model(input txn_t t);
        res_t e;
        bit legal;
        int nbytes, off, a, c, tlim;
        logic [31:0] v;
        e = '{default: 0};
        e.done = 1;
        legal = t.write ? (t.f3 <= 3'd2) : (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        nbytes = 1 << t.f3[1:0];
        if (legal && (t.addr % nbytes) != 0) legal = 0;
        if (!legal) begin
            e.err = 2'b01; e.lat = 1; e.iss = 0;
            return e;
        end
        off     = int'(t.addr % 4);
        e.maddr = t.addr - (t.addr % 4);
        e.be    = 4'(((1 << nbytes) - 1) << off);
        e.mwr   = t.write;
        case (nbytes)
            1:       e.mwd = (t.wdata & 32'hFF) * 32'h01010101;
            2:       e.mwd = (t.wdata & 32'hFFFF) * 32'h00010001;
            default: e.mwd = t.wdata;
        endcase
        a = t.rdy_dly + 1;
        if (a > 16) begin
            e.err = 2'b10; e.iss = 16; e.lat = 17;
            return e;
        end
        e.iss = a;
        if (t.write) begin
            e.lat = a + 1;
            return e;
        end
        c    = a + t.rv_dly;
        tlim = (a + 1 > 16) ? a + 1 : 16;
        if (c > tlim) begin
            e.err = 2'b10; e.lat = tlim + 1;
            return e;
        end
        e.lat = c + 1;
        v = t.rdata >> (8 * off);
        if (nbytes == 1) begin
            v = v & 32'hFF;
            if (t.f3 == 3'd0 && v >= 128) v = v - 256;
        end else if (nbytes == 2) begin
            v = v & 32'hFFFF;
            if (t.f3 == 3'd1 && v >= 32768) v = v - 65536;
        end
        e.rdata = v;
        return e;
    endfunction

    // Acts as core and bus for one transaction; called at a negedge.
    task automatic run_txn(input txn_t t, output res_t r);
        int iss, since, w;
        bit acc;
        r = '{default: 0};
        w = 0;
        while (!LSU_Req_Ready && w < 10) begin
            @(negedge REG_Clk);
            w++;
        end
        LSU_Req_Valid = 1; LSU_Req_Write = t.write; LSU_Req_Funct3 = t.f3;
        LSU_Req_Addr = t.addr; LSU_Req_WData = t.wdata;
        MEM_Ready = 0; MEM_RValid = 0;
        iss = 0; since = 0; acc = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge REG_Clk);
            LSU_Req_Valid = 0;
            MEM_Ready = 0; MEM_RValid = 0; MEM_RData = $urandom;
            if (LSU_Req_Ready) r.busy_ready = 1;
            if (LSU_Rsp_Valid) begin
                r.done = 1; r.lat = cyc; r.rdata = LSU_Rsp_RData; r.err = LSU_Rsp_Error;
                break;
            end
            // Stray read data during a store must be ignored.
            if (t.write) MEM_RValid = 1'($urandom_range(0, 1));
            if (MEM_Valid) begin
                iss++;
                if (iss == 1) begin
                    r.maddr = MEM_Addr; r.be = MEM_BE; r.mwd = MEM_WData; r.mwr = MEM_Write;
                end else if (MEM_Addr !== r.maddr || MEM_BE !== r.be ||
                             MEM_WData !== r.mwd || MEM_Write !== r.mwr) begin
                    r.unstable = 1;
                end
                if (iss > t.rdy_dly) begin
                    MEM_Ready = 1; acc = 1;
                    if (!t.write && t.rv_dly == 0) begin
                        MEM_RValid = 1; MEM_RData = t.rdata;
                    end
                end
            end else if (acc && !t.write) begin
                since++;
                if (since == t.rv_dly) begin
                    MEM_RValid = 1; MEM_RData = t.rdata;
                end
            end
        end
        r.iss = iss;
        @(negedge REG_Clk);
        MEM_Ready = 0; MEM_RValid = 0;
        r.pulse_bad = LSU_Rsp_Valid;
    endtask

    task automatic compare(input string tag, input res_t e, input res_t g);
        check({tag, ".done"},   32'(g.done), 32'(e.done));
        check({tag, ".err"},    32'(g.err), 32'(e.err));
        check({tag, ".rdata"},  g.rdata, e.rdata);
        check({tag, ".lat"},    32'(g.lat), 32'(e.lat));
        check({tag, ".issue"},  32'(g.iss), 32'(e.iss));
        check({tag, ".stable"}, 32'(g.unstable), 32'd0);
        check({tag, ".busy"},   32'(g.busy_ready), 32'd0);
        check({tag, ".pulse"},  32'(g.pulse_bad), 32'd0);
        if (e.iss > 0) begin
            check({tag, ".maddr"}, g.maddr, e.maddr);
            check({tag, ".be"},    32'(g.be), 32'(e.be));
            check({tag, ".mwr"},   32'(g.mwr), 32'(e.mwr));
            if (e.mwr) check({tag, ".mwdata"}, g.mwd, e.mwd);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd, input int rdy,
                                input int rv, input logic [1:0] err, input logic [31:0] erd,
                                input int lat, input int iss, input logic [31:0] maddr,
                                input logic [3:0] be, input logic [31:0] mwd);
        vec_t v;
        v.t = '{write: w, f3: f3, addr: addr, wdata: wd, rdata: rd, rdy_dly: rdy, rv_dly: rv};
        v.err = err; v.rdata = erd; v.lat = lat; v.iss = iss;
        v.maddr = maddr; v.be = be; v.mwd = mwd;
        return v;
    endfunction

    initial begin
        vec_t tbl[16];
        res_t g, e;
        txn_t t;
        bit   late_rsp;

        REG_Reset = 1; LSU_Req_Valid = 0; LSU_Req_Write = 0; LSU_Req_Funct3 = 0;
        LSU_Req_Addr = 0; LSU_Req_WData = 0; MEM_Ready = 0; MEM_RValid = 0; MEM_RData = 0;
        repeat (2) @(negedge REG_Clk);
        check("rst.req_ready", 32'(LSU_Req_Ready), 32'd1);
        check("rst.rsp_valid", 32'(LSU_Rsp_Valid), 32'd0);
        check("rst.rsp_err",   32'(LSU_Rsp_Error), 32'd0);
        check("rst.mem_valid", 32'(MEM_Valid), 32'd0);
        check("rst.mem_addr",  MEM_Addr, 32'd0);
        check("rst.mem_be",    32'(MEM_BE), 32'd0);
        REG_Reset = 0;
        @(negedge REG_Clk);

        //            w  f3    addr        wdata         rdata         rdy rv  err   rdata         lat iss maddr       be     mwdata
        tbl[0]  = mk(1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        0,  0, 2'd0, 32'h0,        2,  1, 32'h100, 4'hF, 32'hDEADBEEF);
        tbl[1]  = mk(1, 3'd0, 32'h203, 32'h000000A5, 32'h0,        0,  0, 2'd0, 32'h0,        2,  1, 32'h200, 4'h8, 32'hA5A5A5A5);
        tbl[2]  = mk(0, 3'd0, 32'h301, 32'h0,        32'h12348056, 0,  1, 2'd0, 32'hFFFFFF80, 3,  1, 32'h300, 4'h2, 32'h0);
        tbl[3]  = mk(0, 3'd4, 32'h301, 32'h0,        32'h12348056, 0,  1, 2'd0, 32'h00000080, 3,  1, 32'h300, 4'h2, 32'h0);
        tbl[4]  = mk(0, 3'd5, 32'h302, 32'h0,        32'h12348056, 0,  1, 2'd0, 32'h00001234, 3,  1, 32'h300, 4'hC, 32'h0);
        tbl[5]  = mk(0, 3'd2, 32'h102, 32'h0,        32'h0,        0,  1, 2'd1, 32'h0,        1,  0, 32'h0,   4'h0, 32'h0);
        tbl[6]  = mk(0, 3'd1, 32'h302, 32'h0,        32'h80001234, 0,  0, 2'd0, 32'hFFFF8000, 2,  1, 32'h300, 4'hC, 32'h0);
        tbl[7]  = mk(0, 3'd2, 32'h040, 32'h0,        32'h0,        99, 0, 2'd2, 32'h0,        17, 16, 32'h40, 4'hF, 32'h0);
        tbl[8]  = mk(0, 3'd3, 32'h000, 32'h0,        32'h0,        0,  1, 2'd1, 32'h0,        1,  0, 32'h0,   4'h0, 32'h0);
        tbl[9]  = mk(1, 3'd4, 32'h000, 32'h55,       32'h0,        0,  0, 2'd1, 32'h0,        1,  0, 32'h0,   4'h0, 32'h0);
        tbl[10] = mk(1, 3'd1, 32'h102, 32'h1234BEEF, 32'h0,        3,  0, 2'd0, 32'h0,        5,  4, 32'h100, 4'hC, 32'hBEEFBEEF);
        tbl[11] = mk(0, 3'd2, 32'h010, 32'h0,        32'hCAFEF00D, 2,  3, 2'd0, 32'hCAFEF00D, 7,  3, 32'h10,  4'hF, 32'h0);
        tbl[12] = mk(0, 3'd2, 32'h020, 32'h0,        32'h0,        5, 99, 2'd2, 32'h0,        17, 6, 32'h20,  4'hF, 32'h0);
        tbl[13] = mk(0, 3'd2, 32'h024, 32'h0,        32'h01234567, 15, 1, 2'd0, 32'h01234567, 18, 16, 32'h24, 4'hF, 32'h0);
        tbl[14] = mk(0, 3'd5, 32'h301, 32'h0,        32'h0,        0,  1, 2'd1, 32'h0,        1,  0, 32'h0,   4'h0, 32'h0);
        tbl[15] = mk(0, 3'd0, 32'h300, 32'h0,        32'h0000007F, 0,  2, 2'd0, 32'h0000007F, 4,  1, 32'h300, 4'h1, 32'h0);

        for (int i = 0; i < 16; i++) begin
            e = '{default: 0};
            e.done = 1; e.err = tbl[i].err; e.rdata = tbl[i].rdata; e.lat = tbl[i].lat;
            e.iss = tbl[i].iss; e.maddr = tbl[i].maddr; e.be = tbl[i].be;
            e.mwd = tbl[i].mwd; e.mwr = tbl[i].t.write;
            run_txn(tbl[i].t, g);
            compare($sformatf("tbl%0d", i), e, g);
        end

        // Reset while waiting for read data: immediate return to idle, and
        // read data arriving afterwards must not produce a response.
        LSU_Req_Valid = 1; LSU_Req_Write = 0; LSU_Req_Funct3 = 3'd2;
        LSU_Req_Addr = 32'h80; MEM_Ready = 0;
        @(negedge REG_Clk);
        LSU_Req_Valid = 0;
        check("rstw.mem_valid", 32'(MEM_Valid), 32'd1);
        MEM_Ready = 1;
        @(negedge REG_Clk);
        MEM_Ready = 0;
        check("rstw.in_wait", 32'({MEM_Valid, LSU_Req_Ready}), 32'd0);
        REG_Reset = 1;
        #1;
        check("rstw.req_ready", 32'(LSU_Req_Ready), 32'd1);
        check("rstw.mem_valid0", 32'(MEM_Valid), 32'd0);
        check("rstw.rsp_valid", 32'(LSU_Rsp_Valid), 32'd0);
        @(negedge REG_Clk);
        REG_Reset = 0; MEM_RValid = 1; MEM_RData = 32'h11223344;
        late_rsp = 0;
        repeat (4) begin
            @(negedge REG_Clk);
            MEM_RValid = 0;
            if (LSU_Rsp_Valid) late_rsp = 1;
        end
        check("rstw.no_late_rsp", 32'(late_rsp), 32'd0);

        for (int i = 0; i < 300; i++) begin
            t.write = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) t.f3 = 3'($urandom_range(0, 7));
            else if (t.write)              t.f3 = 3'($urandom_range(0, 2));
            else begin
                t.f3 = 3'($urandom_range(0, 4));
                if (t.f3 == 3'd3) t.f3 = 3'd5;
            end
            t.addr = $urandom;
            if ($urandom_range(0, 3) != 0)
                t.addr = t.addr - (t.addr % (32'd1 << t.f3[1:0]));
            t.wdata = $urandom;
            t.rdata = $urandom;
            t.rdy_dly = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 2));
            t.rv_dly  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
            run_txn(t, g);
            compare($sformatf("rnd%0d", i), model(t), g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
